// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
//   fetch_state_e  : sequencer states (IDLE, FETCH, HOLD, HALTED)
//   FETCH_AW/DW    : default ROM address / instruction widths
//   FETCH_RESET_PC : default program counter value after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALTED
  } fetch_state_e;

  localparam int unsigned FETCH_AW       = 4;
  localparam int unsigned FETCH_DW       = 16;
  localparam int unsigned FETCH_RESET_PC = 0;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch sequencer.
//   load/load_addr : load the PC (wins over inc)
//   inc            : advance the PC by one, modulo 2^AW
//   pc             : current PC value
//   pc_wrap        : one-cycle pulse after an increment from all-ones to zero
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned AW       = FETCH_AW,
  parameter int unsigned RESET_PC = FETCH_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          inc,
  output logic [AW-1:0] pc,
  output logic          pc_wrap
);

  logic [AW-1:0] pc_d, pc_q;
  logic          wrap_d, wrap_q;

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d   = pc_q + AW'(1);
      wrap_d = (pc_q == '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= AW'(RESET_PC);
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  assign pc      = pc_q;
  assign pc_wrap = wrap_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, waits out ROM latency, latches
// the ROM word into an instruction register and offers it to decode over a
// valid/ready handshake. Supports start, halt and jump from core control.
//   start/halt/jump_valid/jump_addr : control inputs (halt > jump > start)
//   rom_addr/rom_data               : ROM read port (rom_addr == PC)
//   instr/instr_pc/instr_valid      : held instruction toward decode
//   instr_ready                     : decode accepts the held instruction
//   busy                            : high while in FETCH or HOLD
//   pc_wrap                         : pulse after PC wraps to zero
// Optional macro FETCH_SEQ_COUNT_EN adds fetch_count[15:0], a saturating
// count of completed handshakes.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned AW       = FETCH_AW,
  parameter int unsigned DW       = FETCH_DW,
  parameter int unsigned ROM_LAT  = 0,
  parameter int unsigned RESET_PC = FETCH_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  input  logic          jump_valid,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          busy,
  output logic          pc_wrap
`ifdef FETCH_SEQ_COUNT_EN
  ,
  output logic [15:0]   fetch_count
`endif
);

  localparam int unsigned CW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

  fetch_state_e  state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [DW-1:0] instr_d, instr_q;
  logic [AW-1:0] instr_pc_d, instr_pc_q;
  logic          instr_valid_d, instr_valid_q;
  logic          busy_d, busy_q;
  logic [AW-1:0] pc;
  logic          active, capture, handshake, pc_load;

  assign active    = (state_q == FETCH) || (state_q == HOLD);
  // Capture and handshake only happen when neither halt nor jump overrides them.
  assign capture   = (state_q == FETCH) && !halt && !jump_valid &&
                     (cnt_q == CW'(ROM_LAT));
  assign handshake = (state_q == HOLD) && instr_valid_q && instr_ready &&
                     !halt && !jump_valid;
  assign pc_load   = jump_valid && !halt;

  fetch_pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load),
    .load_addr (jump_addr),
    .inc       (capture),
    .pc        (pc),
    .pc_wrap   (pc_wrap)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (!halt && !jump_valid && start) state_d = FETCH;
      end
      FETCH, HOLD: begin
        if (halt)            state_d = HALTED;
        else if (jump_valid) state_d = FETCH;
        else if (capture)    state_d = HOLD;
        else if (handshake)  state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic; busy is registered from the next state.
  always_comb begin
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    cnt_d         = '0;
    if (active && (halt || jump_valid)) begin
      instr_valid_d = 1'b0;
    end else if (capture) begin
      instr_d       = rom_data;
      instr_pc_d    = pc;
      instr_valid_d = 1'b1;
    end else if (handshake) begin
      instr_valid_d = 1'b0;
    end
    if ((state_q == FETCH) && !halt && !jump_valid && !capture) begin
      cnt_d = cnt_q + CW'(1);
    end
    busy_d = (state_d == FETCH) || (state_d == HOLD);
  end

  assign rom_addr    = pc;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;

`ifdef FETCH_SEQ_COUNT_EN
  logic [15:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (handshake && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (ROM_LAT=0 and ROM_LAT=2) share
// the control inputs; each is compared every cycle against its own
// transaction-level model, plus directed checks from the test plan.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, jump_valid, instr_ready;
  logic [3:0]  jump_addr;
  logic [15:0] mem [16];

  logic [3:0]  ra0, ipc0, ra2, ipc2;
  logic [15:0] rd0, ins0, rd2, ins2;
  logic        v0, b0, w0, v2, b2, w2;
`ifdef FETCH_SEQ_COUNT_EN
  logic [15:0] fc0, fc2;
`endif

  always #5 clk = ~clk;

  assign rd0 = mem[ra0];
  assign rd2 = mem[ra2];

  fetch_sequencer #(.AW(4), .DW(16), .ROM_LAT(0), .RESET_PC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .rom_addr(ra0), .rom_data(rd0), .instr(ins0), .instr_pc(ipc0),
    .instr_valid(v0), .instr_ready(instr_ready), .busy(b0), .pc_wrap(w0)
`ifdef FETCH_SEQ_COUNT_EN
    , .fetch_count(fc0)
`endif
  );

  fetch_sequencer #(.AW(4), .DW(16), .ROM_LAT(2), .RESET_PC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .rom_addr(ra2), .rom_data(rd2), .instr(ins2), .instr_pc(ipc2),
    .instr_valid(v2), .instr_ready(instr_ready), .busy(b2), .pc_wrap(w2)
`ifdef FETCH_SEQ_COUNT_EN
    , .fetch_count(fc2)
`endif
  );

  // Transaction-level view: running or not, word held or not, cycles left
  // before the ROM word is usable, and a running handshake tally.
  typedef struct {
    bit          active;
    bit          valid;
    int unsigned wait_left;
    logic [3:0]  pc;
    logic [15:0] instr;
    logic [3:0]  ipc;
    bit          wrap;
    int unsigned hs;
  } model_t;

  model_t m0, m2;
  int unsigned errors = 0;
  int unsigned checks = 0;

  function automatic model_t fresh();
    model_t r;
    r.active = 0; r.valid = 0; r.wait_left = 0; r.pc = 4'd0;
    r.instr = 16'd0; r.ipc = 4'd0; r.wrap = 0; r.hs = 0;
    return r;
  endfunction

  function automatic model_t step(model_t m, int unsigned lat, bit st, bit hl,
                                  bit jv, logic [3:0] ja, bit rdy);
    model_t n = m;
    n.wrap = 0;
    if (hl) begin
      n.active = 0;
      n.valid  = 0;
    end else if (jv) begin
      n.pc = ja;
      if (m.active) begin
        n.valid     = 0;
        n.wait_left = lat;
      end
    end else if (!m.active) begin
      if (st) begin
        n.active    = 1;
        n.wait_left = lat;
      end
    end else if (!m.valid) begin
      if (m.wait_left == 0) begin
        n.instr = mem[m.pc];
        n.ipc   = m.pc;
        n.valid = 1;
        n.pc    = m.pc + 4'd1;
        n.wrap  = (m.pc == 4'hF);
      end else begin
        n.wait_left = m.wait_left - 1;
      end
    end else if (rdy) begin
      n.valid     = 0;
      n.wait_left = lat;
      if (n.hs < 65535) n.hs = n.hs + 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("d0_rom_addr", 32'(ra0),  32'(m0.pc));
    chk("d0_instr",    32'(ins0), 32'(m0.instr));
    chk("d0_instr_pc", 32'(ipc0), 32'(m0.ipc));
    chk("d0_valid",    32'(v0),   32'(m0.valid));
    chk("d0_busy",     32'(b0),   32'(m0.active));
    chk("d0_pc_wrap",  32'(w0),   32'(m0.wrap));
    chk("d2_rom_addr", 32'(ra2),  32'(m2.pc));
    chk("d2_instr",    32'(ins2), 32'(m2.instr));
    chk("d2_instr_pc", 32'(ipc2), 32'(m2.ipc));
    chk("d2_valid",    32'(v2),   32'(m2.valid));
    chk("d2_busy",     32'(b2),   32'(m2.active));
    chk("d2_pc_wrap",  32'(w2),   32'(m2.wrap));
`ifdef FETCH_SEQ_COUNT_EN
    chk("d0_fetch_count", 32'(fc0), 32'(m0.hs));
    chk("d2_fetch_count", 32'(fc2), 32'(m2.hs));
`endif
  endtask

  task automatic cycle(input bit st, input bit hl, input bit jv,
                       input logic [3:0] ja, input bit rdy);
    model_t n0, n2;
    start = st; halt = hl; jump_valid = jv; jump_addr = ja; instr_ready = rdy;
    n0 = step(m0, 0, st, hl, jv, ja, rdy);
    n2 = step(m2, 2, st, hl, jv, ja, rdy);
    @(posedge clk);
    #1;
    m0 = n0;
    m2 = n2;
    compare_all();
  endtask

  initial begin
    int unsigned k;
    bit found;

    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1A2B; mem[1] = 16'h3C4D; mem[2] = 16'h5E6F; mem[3] = 16'h7081;

    rst_n = 1'b0; start = 0; halt = 0; jump_valid = 0; jump_addr = 4'd0; instr_ready = 0;
    m0 = fresh();
    m2 = fresh();
    #2;
    compare_all();
    #10 rst_n = 1'b1;

    // Stream mem[0..3] with ready held high.
    cycle(1, 0, 0, 4'd0, 1);
    cycle(0, 0, 0, 4'd0, 1);
    chk("first_instr", 32'(ins0), 32'h1A2B);
    chk("first_ipc",   32'(ipc0), 32'h0);
    chk("first_valid", 32'(v0),   32'h1);
    cycle(0, 0, 0, 4'd0, 1);
    chk("lat2_not_yet", 32'(v2), 32'h0);
    cycle(0, 0, 0, 4'd0, 1);
    chk("lat2_capture", 32'(ins2), 32'h1A2B);
    chk("lat2_valid",   32'(v2),   32'h1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 4'd0, 1);
    chk("fourth_instr", 32'(ins0), 32'h7081);
    chk("fourth_ipc",   32'(ipc0), 32'h3);
    cycle(0, 0, 0, 4'd0, 1);

    // Halt, jump to 1 while halted, resume and stall decode for 5 cycles.
    cycle(0, 1, 0, 4'd0, 1);
    cycle(0, 0, 1, 4'd1, 0);
    chk("halted_jump_busy", 32'(b0), 32'h0);
    cycle(1, 0, 0, 4'd0, 0);
    cycle(0, 0, 0, 4'd0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 4'd0, 0);
    chk("stall_instr", 32'(ins0), 32'h3C4D);
    chk("stall_ipc",   32'(ipc0), 32'h1);
    chk("stall_addr",  32'(ra0),  32'h2);

    // Jump with ready in the same cycle drops the held word; run through the wrap.
    cycle(0, 0, 1, 4'hE, 1);
    chk("jump_drop_valid", 32'(v0), 32'h0);
    cycle(0, 0, 0, 4'd0, 1);
    chk("jump_ipc_e", 32'(ipc0), 32'hE);

    // Run until dut0 is mid-fetch at pc=5, then halt there.
    found = 0;
    k = 0;
    while (!found && k < 200) begin
      if (m0.active && !m0.valid && m0.pc == 4'd5) found = 1;
      else cycle(0, 0, 0, 4'd0, 1);
      k++;
    end
    chk("reach_pc5", 32'(found), 32'h1);
    cycle(0, 1, 1, 4'd9, 1);
    chk("halt_valid", 32'(v0),  32'h0);
    chk("halt_pc",    32'(ra0), 32'h5);
    chk("halt_busy",  32'(b0),  32'h0);
    cycle(1, 0, 0, 4'd0, 0);
    k = 0;
    while (!m0.valid && k < 50) begin
      cycle(0, 0, 0, 4'd0, 0);
      k++;
    end
    chk("resume_ipc", 32'(ipc0), 32'h5);

    // Random control traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) == 0, 4'($urandom), $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset while holding a word.
    cycle(1, 0, 0, 4'd0, 0);
    k = 0;
    while (!m0.valid && k < 50) begin
      cycle(1, 0, 0, 4'd0, 0);
      k++;
    end
    chk("hold_before_reset", 32'(v0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    m0 = fresh();
    m2 = fresh();
    compare_all();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) == 0, 4'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
